// File: rtl/inst_wb_if_pkg.sv
// Shared types and widths for the instruction-fetch Wishbone bridge.
package inst_wb_if_pkg;

    localparam int INST_ADDR_W  = 32;
    localparam int INST_W       = 32;
    localparam int STALL_W      = 6;
    localparam int IF_STALL_BIT = 1;

    typedef enum logic [1:0] {
        WB_IDLE       = 2'b00,
        WB_BUSY       = 2'b01,
        WB_WAIT_STALL = 2'b10
    } wb_state_e;

endpackage

// File: rtl/inst_wb_if_if.sv
// Wishbone B4 classic read-only bus between the fetch bridge (master) and the system bus (slave).
interface inst_wb_if_if;
    import inst_wb_if_pkg::*;

    logic [INST_ADDR_W-1:0] wb_adr_o;
    logic [INST_W-1:0]      wb_dat_i;
    logic                   wb_ack_i;
    logic                   wb_cyc_o;
    logic                   wb_stb_o;
    logic                   wb_we_o;
    logic [3:0]             wb_sel_o;

    modport master (
        output wb_adr_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_adr_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o,
        output wb_dat_i, wb_ack_i
    );

endinterface

// File: rtl/inst_wb_if.sv
// Instruction-fetch to Wishbone classic bridge: one single-beat read per fetch, stalls IF until ack.
// Optional fetch timeout enabled by defining WB_TIMEOUT_EN.
module inst_wb_if
    import inst_wb_if_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STALL_W-1:0]     stall_i,
    input  logic                   cpu_ce_i,
    input  logic [INST_ADDR_W-1:0] cpu_addr_i,
    output logic [INST_W-1:0]      cpu_data_o,
    output logic                   stallreq_o,
    output logic                   bus_err_o,
    inst_wb_if_if.master           wb
);

    wb_state_e              state_q;
    wb_state_e              state_d;
    logic [INST_ADDR_W-1:0] adr_q;
    logic                   cyc_q;
    logic [3:0]             sel_q;
    logic [INST_W-1:0]      rd_buf_q;
    logic                   timeout;
    logic                   done;
    logic                   if_stalled;
    logic                   unused_stall_bits;

    assign if_stalled        = stall_i[IF_STALL_BIT];
    assign unused_stall_bits = ^{stall_i[STALL_W-1:IF_STALL_BIT+1], stall_i[IF_STALL_BIT-1:0]};
    assign done              = (state_q == WB_BUSY) && (wb.wb_ack_i || timeout);

`ifdef WB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] to_cnt_q;

    // Counter is held at zero outside BUSY, so every fetch starts counting from 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_q <= '0;
        end else if (state_q != WB_BUSY) begin
            to_cnt_q <= '0;
        end else if (!wb.wb_ack_i) begin
            to_cnt_q <= to_cnt_q + 8'd1;
        end
    end

    assign timeout   = (state_q == WB_BUSY) && !wb.wb_ack_i && (to_cnt_q == TO_LAST);
    assign bus_err_o = timeout;
`else
    localparam int unsigned UNUSED_TIMEOUT = TIMEOUT_CYCLES;
    assign timeout   = 1'b0;
    assign bus_err_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= WB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        stallreq_o = 1'b0;
        cpu_data_o = '0;
        case (state_q)
            WB_IDLE: begin
                stallreq_o = cpu_ce_i;
                if (cpu_ce_i) begin
                    state_d = WB_BUSY;
                end
            end
            WB_BUSY: begin
                stallreq_o = !wb.wb_ack_i && !timeout;
                if (wb.wb_ack_i) begin
                    cpu_data_o = wb.wb_dat_i;
                end
                if (done) begin
                    state_d = if_stalled ? WB_WAIT_STALL : WB_IDLE;
                end
            end
            WB_WAIT_STALL: begin
                cpu_data_o = rd_buf_q;
                if (!if_stalled) begin
                    state_d = WB_IDLE;
                end
            end
            default: state_d = WB_IDLE;
        endcase
    end

    // Bus outputs are registered; the address is latched once so pc movement mid-cycle is harmless.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            adr_q    <= '0;
            cyc_q    <= 1'b0;
            sel_q    <= 4'h0;
            rd_buf_q <= '0;
        end else if ((state_q == WB_IDLE) && cpu_ce_i) begin
            adr_q <= cpu_addr_i;
            cyc_q <= 1'b1;
            sel_q <= 4'hF;
        end else if (done) begin
            cyc_q    <= 1'b0;
            sel_q    <= 4'h0;
            rd_buf_q <= wb.wb_ack_i ? wb.wb_dat_i : '0;
        end
    end

    assign wb.wb_adr_o = adr_q;
    assign wb.wb_cyc_o = cyc_q;
    assign wb.wb_stb_o = cyc_q;
    assign wb.wb_we_o  = 1'b0;
    assign wb.wb_sel_o = sel_q;

endmodule

// File: tb/tb_inst_wb_if.sv
// Directed bench for inst_wb_if with a transaction-level reference model and a reactive bus slave.
module tb_inst_wb_if;
    import inst_wb_if_pkg::*;

    localparam int unsigned TB_TO = 4;
`ifdef WB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  stall = '0;
    logic        ce = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] cpu_data;
    logic        stallreq;
    logic        bus_err;

    int n_cmp  = 0;
    int n_fail = 0;

    inst_wb_if_if wb ();

    inst_wb_if #(.TIMEOUT_CYCLES(TB_TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (stall),
        .cpu_ce_i   (ce),
        .cpu_addr_i (addr),
        .cpu_data_o (cpu_data),
        .stallreq_o (stallreq),
        .bus_err_o  (bus_err),
        .wb         (wb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Slave memory contents: address 4 holds a fixed opcode, others derive from the address.
    function automatic logic [31:0] slave_word(input logic [31:0] a);
        if (a == 32'h4) return 32'h3401_1100;
        return {a[15:0], ~a[15:0]};
    endfunction

    int slv_waits = 0;
    int slv_cnt   = 0;
    bit slv_hang  = 1'b0;
    bit slv_spur  = 1'b0;

    initial begin
        wb.wb_ack_i = 1'b0;
        wb.wb_dat_i = 32'hDEAD_BEEF;
    end

    always @(posedge clk) begin
        #1;
        if (wb.wb_cyc_o && wb.wb_stb_o && !slv_hang) begin
            if (slv_cnt >= slv_waits) begin
                wb.wb_ack_i = 1'b1;
                wb.wb_dat_i = slave_word(wb.wb_adr_o);
                slv_cnt     = 0;
            end else begin
                wb.wb_ack_i = 1'b0;
                wb.wb_dat_i = 32'hDEAD_BEEF;
                slv_cnt++;
            end
        end else begin
            wb.wb_ack_i = slv_spur && !wb.wb_cyc_o;
            wb.wb_dat_i = 32'hDEAD_BEEF;
            slv_cnt     = 0;
        end
    end

    // Reference model: one open bus transaction or one held word, nothing else.
    logic        m_open = 1'b0, m_held = 1'b0;
    logic [31:0] m_adr = '0, m_word = '0;
    int          m_age = 0;
    logic        n_open = 1'b0, n_held = 1'b0;
    logic [31:0] n_adr = '0, n_word = '0;
    int          n_age = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_open <= 1'b0;
            m_held <= 1'b0;
            m_adr  <= '0;
            m_word <= '0;
            m_age  <= 0;
        end else begin
            m_open <= n_open;
            m_held <= n_held;
            m_adr  <= n_adr;
            m_word <= n_word;
            m_age  <= n_age;
        end
    end

    always @(negedge clk) begin : cmp_proc
        logic [31:0] e_data;
        logic        e_sr, e_err, fin;
        if (rst) begin
            e_data = '0;
            e_sr   = 1'b0;
            e_err  = 1'b0;
            fin    = 1'b0;
            if (m_open) begin
                if (wb.wb_ack_i) begin
                    e_data = wb.wb_dat_i;
                    fin    = 1'b1;
                end else if (TO_EN && (m_age == int'(TB_TO) - 1)) begin
                    e_err = 1'b1;
                    fin   = 1'b1;
                end else begin
                    e_sr = 1'b1;
                end
            end else if (m_held) begin
                e_data = m_word;
            end else begin
                e_sr = ce;
            end
            chk("adr", wb.wb_adr_o, m_adr);
            chk("cyc", {31'd0, wb.wb_cyc_o}, {31'd0, m_open});
            chk("stb", {31'd0, wb.wb_stb_o}, {31'd0, m_open});
            chk("sel", {28'd0, wb.wb_sel_o}, m_open ? 32'hF : 32'h0);
            chk("we", {31'd0, wb.wb_we_o}, 32'h0);
            chk("stallreq", {31'd0, stallreq}, {31'd0, e_sr});
            chk("cpu_data", cpu_data, e_data);
            chk("bus_err", {31'd0, bus_err}, {31'd0, e_err});

            n_open = m_open;
            n_held = m_held;
            n_adr  = m_adr;
            n_word = m_word;
            n_age  = m_age;
            if (m_open) begin
                if (fin) begin
                    n_open = 1'b0;
                    n_held = stall[IF_STALL_BIT];
                    n_word = wb.wb_ack_i ? wb.wb_dat_i : 32'h0;
                end else begin
                    n_age = m_age + 1;
                end
            end else if (m_held) begin
                if (!stall[IF_STALL_BIT]) n_held = 1'b0;
            end else if (ce) begin
                n_open = 1'b1;
                n_adr  = addr;
                n_age  = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset state
        repeat (2) smp();
        chk("rst_adr", wb.wb_adr_o, 32'h0);
        chk("rst_cyc", {31'd0, wb.wb_cyc_o}, 32'h0);
        chk("rst_sel", {28'd0, wb.wb_sel_o}, 32'h0);
        chk("rst_data", cpu_data, 32'h0);
        chk("rst_err", {31'd0, bus_err}, 32'h0);
        tick();
        rst = 1'b1;

        // Zero-wait fetch from address 4
        slv_waits = 0;
        tick(); ce = 1'b1; addr = 32'h4;
        smp(); chk("t1_req_stallreq", {31'd0, stallreq}, 32'h1);
        tick(); ce = 1'b0;
        smp();
        chk("t1_cyc", {31'd0, wb.wb_cyc_o}, 32'h1);
        chk("t1_adr", wb.wb_adr_o, 32'h4);
        chk("t1_data", cpu_data, 32'h3401_1100);
        chk("t1_stallreq", {31'd0, stallreq}, 32'h0);
        tick(); smp();
        chk("t1_idle_cyc", {31'd0, wb.wb_cyc_o}, 32'h0);

        // Three wait states
        slv_waits = 3;
        tick(); ce = 1'b1; addr = 32'h10;
        begin
            int sr_cnt, cyc_cnt;
            logic [31:0] got;
            sr_cnt = 0; cyc_cnt = 0; got = '0;
            for (int i = 0; i < 6; i++) begin
                smp();
                sr_cnt  += int'(stallreq);
                cyc_cnt += int'(wb.wb_cyc_o);
                if (wb.wb_cyc_o && wb.wb_ack_i) got = cpu_data;
                tick(); ce = 1'b0;
            end
            chk("t2_stallreq_cycles", sr_cnt, 32'd4);
            chk("t2_cyc_cycles", cyc_cnt, 32'd4);
            chk("t2_data", got, 32'h0010_FFEF);
        end

        // Ack while IF is stalled, then hold with spurious acks on the bus
        slv_waits = 0;
        tick(); ce = 1'b1; addr = 32'h20;
        smp();
        tick(); ce = 1'b0; stall = 6'b000010; slv_spur = 1'b1;
        smp(); chk("t3_ack_data", cpu_data, 32'h0020_FFDF);
        for (int i = 0; i < 3; i++) begin
            tick(); smp();
            chk("t3_hold_data", cpu_data, 32'h0020_FFDF);
            chk("t3_bus_idle", {31'd0, wb.wb_cyc_o}, 32'h0);
        end
        tick(); stall = '0; slv_spur = 1'b0;
        smp(); chk("t3_last_hold", cpu_data, 32'h0020_FFDF);
        tick(); smp();
        chk("t3_rel_data", cpu_data, 32'h0);

        // Asynchronous reset in the middle of a bus cycle
        slv_waits = 5;
        tick(); ce = 1'b1; addr = 32'h30;
        smp();
        tick(); addr = 32'h34;
        smp(); chk("t4_busy_cyc", {31'd0, wb.wb_cyc_o}, 32'h1);
        #2 rst = 1'b0; slv_waits = 0;
        #1;
        chk("t4_async_cyc", {31'd0, wb.wb_cyc_o}, 32'h0);
        chk("t4_async_stb", {31'd0, wb.wb_stb_o}, 32'h0);
        chk("t4_async_sel", {28'd0, wb.wb_sel_o}, 32'h0);
        tick(); rst = 1'b1;
        smp(); chk("t4_req", {31'd0, stallreq}, 32'h1);
        tick(); smp();
        chk("t4_adr", wb.wb_adr_o, 32'h34);
        chk("t4_data", cpu_data, 32'h0034_FFCB);
        tick(); ce = 1'b0;
        smp(); chk("t4_done", {31'd0, wb.wb_cyc_o}, 32'h0);

        // Address moves during BUSY
        slv_waits = 2;
        tick(); ce = 1'b1; addr = 32'h8;
        smp();
        tick(); addr = 32'hC;
        smp(); chk("t5_adr_w1", wb.wb_adr_o, 32'h8);
        tick(); smp(); chk("t5_adr_w2", wb.wb_adr_o, 32'h8);
        tick(); smp();
        chk("t5_ack_adr", wb.wb_adr_o, 32'h8);
        chk("t5_ack_data", cpu_data, 32'h0008_FFF7);
        tick(); smp();
        chk("t5_gap_cyc", {31'd0, wb.wb_cyc_o}, 32'h0);
        chk("t5_gap_stallreq", {31'd0, stallreq}, 32'h1);
        tick(); ce = 1'b0;
        smp();
        chk("t5_next_adr", wb.wb_adr_o, 32'hC);
        chk("t5_next_cyc", {31'd0, wb.wb_cyc_o}, 32'h1);
        for (int i = 0; i < 8 && wb.wb_cyc_o; i++) begin
            tick(); smp();
        end
        chk("t5_drain", {31'd0, wb.wb_cyc_o}, 32'h0);

        // Back-to-back single-cycle fetches leave one idle bus cycle between them
        slv_waits = 0;
        n = 0;
        tick(); ce = 1'b1; addr = 32'h50;
        for (int i = 0; i < 6; i++) begin
            smp();
            n += int'(wb.wb_cyc_o);
            tick();
        end
        ce = 1'b0;
        chk("b2b_cycles", n, 32'd3);

`ifdef WB_TIMEOUT_EN
        // Slave never acks: fetch abandoned after TB_TO busy cycles
        slv_hang = 1'b1;
        tick(); ce = 1'b1; addr = 32'h40;
        smp();
        tick(); ce = 1'b0;
        n = 0;
        for (int i = 0; i < int'(TB_TO); i++) begin
            smp();
            n += int'(wb.wb_cyc_o);
            if (i == int'(TB_TO) - 1) begin
                chk("t6_err", {31'd0, bus_err}, 32'h1);
                chk("t6_data", cpu_data, 32'h0);
                chk("t6_stallreq", {31'd0, stallreq}, 32'h0);
            end else begin
                chk("t6_no_err", {31'd0, bus_err}, 32'h0);
            end
            tick();
        end
        smp();
        chk("t6_cyc_drop", {31'd0, wb.wb_cyc_o}, 32'h0);
        chk("t6_err_pulse", {31'd0, bus_err}, 32'h0);
        chk("t6_busy_cycles", n, TB_TO);
        slv_hang = 1'b0;
`endif

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
